inst_fetch_buffer: RTL and testbench

Dual-issue instruction fetch buffer between the fetch stage and the FIFO→ID pipeline register. Accepts up to two instructions per cycle from fetch, stores them with their PCs in a circular buffer, and presents up to two in-order instructions per cycle to the downstream stage over the `fifo_valid`/`fifo_ready` handshake, together with `fetch_buf_empty`. A flush empties the buffer in one cycle.

---
 rtl/inst_fetch_buffer.sv | 115 +++++++++++
 tb/tb_inst_fetch_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// Dual-issue instruction fetch buffer.
// Circular store of {inst, pc} pairs; accepts up to two instructions per cycle from fetch and
// presents up to two in-order instructions per cycle (show-ahead) to the decode side.
module inst_fetch_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fifo_flush,
  input  logic        if_valid,
  input  logic        if_inst1_valid,
  input  logic [31:0] if_inst0,
  input  logic [31:0] if_inst1,
  input  logic [31:0] if_pc0,
  input  logic [31:0] if_pc1,
  output logic        if_ready,
  output logic        fifo_valid,
  input  logic        fifo_ready,
  output logic        fifo_inst1_valid,
  output logic [31:0] inst0_o,
  output logic [31:0] inst1_o,
  output logic [31:0] pc0_o,
  output logic [31:0] pc1_o,
  output logic        fetch_buf_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [AW-1:0] wp_plus1, rp_plus1;
  logic          push_en, pop_en;
  logic [1:0]    push_n, pop_n;

  // Second slot of a pair lives one entry later; the AW-bit add wraps at DEPTH.
  assign wp_plus1 = wp_q + AW'(1);
  assign rp_plus1 = rp_q + AW'(1);

  // Status flags depend on the registered occupancy only, so a same-cycle pop never
  // feeds back into if_ready.
  assign if_ready         = (cnt_q <= CW'(DEPTH - 2));
  assign fifo_valid       = (cnt_q != '0);
  assign fifo_inst1_valid = (cnt_q >= CW'(2));
  assign fetch_buf_empty  = (cnt_q == '0);

  assign push_en = if_valid & if_ready;
  assign pop_en  = fifo_valid & fifo_ready;
  assign push_n  = push_en ? (if_inst1_valid ? 2'd2 : 2'd1) : 2'd0;
  assign pop_n   = pop_en ? (fifo_inst1_valid ? 2'd2 : 2'd1) : 2'd0;

  // Next-state for pointers and occupancy; flush overrides push and pop.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (fifo_flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      wp_d  = wp_q + AW'(push_n);
      rp_d  = rp_q + AW'(pop_n);
      cnt_d = cnt_q + CW'(push_n) - CW'(pop_n);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, not reset; stale entries are never visible because outputs are gated
  // by occupancy.
  always_ff @(posedge clk) begin
    if (push_en && !fifo_flush) begin
      inst_mem[wp_q] <= if_inst0;
      pc_mem[wp_q]   <= if_pc0;
      if (if_inst1_valid) begin
        inst_mem[wp_plus1] <= if_inst1;
        pc_mem[wp_plus1]   <= if_pc1;
      end
    end
  end

  // Show-ahead output slots, forced to zero when the slot is not valid.
  always_comb begin
    inst0_o = '0;
    pc0_o   = '0;
    inst1_o = '0;
    pc1_o   = '0;
    if (fifo_valid) begin
      inst0_o = inst_mem[rp_q];
      pc0_o   = pc_mem[rp_q];
    end
    if (fifo_inst1_valid) begin
      inst1_o = inst_mem[rp_plus1];
      pc1_o   = pc_mem[rp_plus1];
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Testbench for inst_fetch_buffer: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the buffer contents.
module tb_inst_fetch_buffer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rstn;
  logic        fifo_flush;
  logic        if_valid;
  logic        if_inst1_valid;
  logic [31:0] if_inst0, if_inst1, if_pc0, if_pc1;
  logic        if_ready;
  logic        fifo_valid;
  logic        fifo_ready;
  logic        fifo_inst1_valid;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic        fetch_buf_empty;

  int total = 0;
  int bad   = 0;

  // Model: program-ordered queue of buffered instructions.
  logic [31:0] q_inst[$];
  logic [31:0] q_pc[$];

  logic [131:0] obs;
  assign obs = {fifo_valid, fifo_inst1_valid, fetch_buf_empty, if_ready,
                inst0_o, pc0_o, inst1_o, pc1_o};

  inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .fifo_flush       (fifo_flush),
    .if_valid         (if_valid),
    .if_inst1_valid   (if_inst1_valid),
    .if_inst0         (if_inst0),
    .if_inst1         (if_inst1),
    .if_pc0           (if_pc0),
    .if_pc1           (if_pc1),
    .if_ready         (if_ready),
    .fifo_valid       (fifo_valid),
    .fifo_ready       (fifo_ready),
    .fifo_inst1_valid (fifo_inst1_valid),
    .inst0_o          (inst0_o),
    .inst1_o          (inst1_o),
    .pc0_o            (pc0_o),
    .pc1_o            (pc1_o),
    .fetch_buf_empty  (fetch_buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected port vector derived from the model queue.
  function automatic logic [131:0] exp_vec();
    int n;
    logic [31:0] a0, b0, a1, b1;
    n  = q_inst.size();
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    if (n >= 1) begin a0 = q_inst[0]; b0 = q_pc[0]; end
    if (n >= 2) begin a1 = q_inst[1]; b1 = q_pc[1]; end
    return {n >= 1, n >= 2, n == 0, n <= DEPTH - 2, a0, b0, a1, b1};
  endfunction

  // Apply one cycle of stimulus, advance the model across the edge, settle 1 time unit.
  task automatic cyc(input bit fl, input bit v, input bit v1, input bit fr,
                     input logic [31:0] i0, input logic [31:0] p0,
                     input logic [31:0] i1, input logic [31:0] p1);
    int n;
    bit rdy;
    int pn;
    fifo_flush = fl; if_valid = v; if_inst1_valid = v1; fifo_ready = fr;
    if_inst0 = i0; if_pc0 = p0; if_inst1 = i1; if_pc1 = p1;
    n   = q_inst.size();
    rdy = (n <= DEPTH - 2);
    @(posedge clk);
    if (fl) begin
      q_inst.delete();
      q_pc.delete();
    end else begin
      if (fr && n >= 1) begin
        pn = (n >= 2) ? 2 : 1;
        repeat (pn) begin
          void'(q_inst.pop_front());
          void'(q_pc.pop_front());
        end
      end
      if (v && rdy) begin
        q_inst.push_back(i0); q_pc.push_back(p0);
        if (v1) begin q_inst.push_back(i1); q_pc.push_back(p1); end
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic clear();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec());
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'hdead0001, 32'h100, 32'hdead0002, 32'h104);
    // Assert reset mid-cycle; outputs must clear without an edge.
    #3 rstn = 1'b0;
    q_inst.delete(); q_pc.delete();
    #1;
    total++;
    if ({fetch_buf_empty, fifo_valid, if_ready, inst0_o} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL reset_async got=%b%b%b %h exp=101 00000000",
               fetch_buf_empty, fifo_valid, if_ready, inst0_o);
    end
    if_valid = 1'b0;
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_pair();
    // No same-cycle bypass: presenting data must not make the output valid before the edge.
    if_valid = 1'b1; if_inst1_valid = 1'b1; fifo_ready = 1'b0;
    #1;
    total++;
    if (fifo_valid !== 1'b0) begin
      bad++; $display("FAIL pair_bypass got=%b exp=0", fifo_valid);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h00000013, 32'h1c000000, 32'h00100093, 32'h1c000004);
    total++;
    if ({fifo_valid, fifo_inst1_valid, inst0_o, pc1_o} !== {2'b11, 32'h13, 32'h1c000004}) begin
      bad++;
      $display("FAIL pair_out got=%b%b %h %h exp=11 00000013 1c000004",
               fifo_valid, fifo_inst1_valid, inst0_o, pc1_o);
    end
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL pair_vec got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_single();
    clear();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h00200113, 32'h1c000008, 32'hffffffff, 32'hffffffff);
    total++;
    if ({fifo_valid, fifo_inst1_valid, inst0_o, inst1_o} !== {2'b10, 32'h00200113, 32'h0}) begin
      bad++;
      $display("FAIL single_out got=%b%b %h %h exp=10 00200113 00000000",
               fifo_valid, fifo_inst1_valid, inst0_o, inst1_o);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
    total++;
    if ({fetch_buf_empty, fifo_valid} !== 2'b10) begin
      bad++; $display("FAIL single_pop got=%b%b exp=10", fetch_buf_empty, fifo_valid);
    end
  endtask

  task automatic test_full();
    clear();
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, $urandom, 32'h2000 + 32'(8 * k), $urandom,
          32'h2004 + 32'(8 * k));
    end
    total++;
    if ({if_ready, fifo_valid} !== 2'b01) begin
      bad++; $display("FAIL full_ready got=%b%b exp=01", if_ready, fifo_valid);
    end
    // Fifth pair must be dropped.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'hbad00000, 32'h9000, 32'hbad00004, 32'h9004);
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL full_drop got=%h exp=%h", obs, exp_vec());
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
    total++;
    if ({if_ready, pc0_o} !== {1'b1, 32'h2008}) begin
      bad++; $display("FAIL full_pop got=%b %h exp=1 00002008", if_ready, pc0_o);
    end
    // Drain the remaining six entries in order.
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({pc0_o, pc1_o} !== {32'h2008 + 32'(8 * k), 32'h200c + 32'(8 * k)}) begin
        bad++; $display("FAIL full_drain%0d got=%h %h", k, pc0_o, pc1_o);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
    end
    total++;
    if (fetch_buf_empty !== 1'b1) begin
      bad++; $display("FAIL full_empty got=%b exp=1", fetch_buf_empty);
    end
  endtask

  task automatic test_stream();
    logic [31:0] next_pc;
    logic [31:0] head_pc;
    clear();
    next_pc = 32'h1c000100;
    head_pc = next_pc;
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, $urandom, next_pc, $urandom, next_pc + 32'd4);
      next_pc += 32'd8;
    end
    for (int k = 0; k < 20; k++) begin
      total++;
      if ({fifo_inst1_valid, pc0_o, pc1_o} !== {1'b1, head_pc, head_pc + 32'd4}) begin
        bad++;
        $display("FAIL stream%0d got=%b %h %h exp=1 %h %h", k, fifo_inst1_valid, pc0_o,
                 pc1_o, head_pc, head_pc + 32'd4);
      end
      cyc(1'b0, 1'b1, 1'b1, 1'b1, $urandom, next_pc, $urandom, next_pc + 32'd4);
      next_pc += 32'd8;
      head_pc += 32'd8;
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL stream_vec%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    clear();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, $urandom, 32'h40, $urandom, 32'h44);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, $urandom, 32'h48, $urandom, 32'h4c);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, $urandom, 32'h50, $urandom, 32'h54);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h77777777, 32'h58, 32'h88888888, 32'h5c);
    total++;
    if ({fetch_buf_empty, fifo_valid, if_ready} !== 3'b101) begin
      bad++;
      $display("FAIL flush_out got=%b%b%b exp=101", fetch_buf_empty, fifo_valid, if_ready);
    end
    idle();
    total++;
    if ({fetch_buf_empty, inst0_o} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL flush_stay got=%b %h exp=1 00000000", fetch_buf_empty, inst0_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    bit fl;
    pc = 32'h80000000;
    for (int k = 0; k < 400; k++) begin
      fl = ($urandom_range(0, 31) == 0);
      cyc(fl, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
          $urandom, pc, $urandom, pc + 32'd4);
      pc += 32'd8;
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    fifo_flush = 1'b0; if_valid = 1'b0; if_inst1_valid = 1'b0; fifo_ready = 1'b0;
    if_inst0 = '0; if_inst1 = '0; if_pc0 = '0; if_pc1 = '0;
    #12 rstn = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_pair();
    test_single();
    test_full();
    test_stream();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
